// File: rtl/uart_bus_ctrl_pkg.sv
// uart_bus_ctrl_pkg
//   Shared definitions for the UART register-bus controller. It holds:
//   - the FSM state enum
//   - the 16550-style register addresses
//   - the DLAB bit index
//   - a helper that gives the configuration write that follows a given one
package uart_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_LCRD = 3'd1,
    W_DLL  = 3'd2,
    W_DLM  = 3'd3,
    W_LCR  = 3'd4,
    W_FCR  = 3'd5,
    GAP    = 3'd6,
    RUN    = 3'd7
  } state_e;

  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;

  localparam int DLAB_BIT = 7;

  // Successor of a configuration-write state. After the last write (W_FCR),
  // the controller goes into normal operation.
  function automatic state_e next_write(input state_e s);
    case (s)
      W_LCRD:  next_write = W_DLL;
      W_DLL:   next_write = W_DLM;
      W_DLM:   next_write = W_LCR;
      W_LCR:   next_write = W_FCR;
      default: next_write = RUN;
    endcase
  endfunction

endpackage

// File: rtl/uart_bus_ctrl_arb.sv
// uart_rr_arb2
//   Two-way round-robin arbiter with a 1-bit last-winner flag.
//   Grants are combinational from the requests. If only one side requests,
//   that side wins every cycle. If both request, the side that did not win
//   last time gets the grant.
//   Ports:
//     clk      clock
//     rst      synchronous active-high reset (last winner := B)
//     en_i     grants are allowed this cycle
//     req_a_i  request from requester A
//     req_b_i  request from requester B
//     gnt_a_o  grant to requester A
//     gnt_b_o  grant to requester B
module uart_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 1 = B won most recently, 0 = A won most recently
  logic last_b_q, last_b_d;

  always_comb begin
    gnt_a_o  = en_i & req_a_i & (~req_b_i | last_b_q);
    gnt_b_o  = en_i & req_b_i & (~req_a_i | ~last_b_q);
    last_b_d = last_b_q;
    if (gnt_a_o) begin
      last_b_d = 1'b0;
    end else if (gnt_b_o) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl
//   Configures a 16550-style UART over its register bus: LCR with DLAB set,
//   DLL, DLM, LCR with DLAB clear, then FCR. Each write can be followed by an
//   optional idle gap. After configuration, the controller shares the bus
//   between a transmit writer (A) and a receive reader (B) using round-robin
//   arbitration.
//   Parameter:
//     CFG_GAP  idle bus cycles after each configuration write (0..7)
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     start                     pulse that requests the configuration sequence
//     divisor, lcr_cfg, fcr_cfg configuration values, sampled on accepted start
//     a_req, a_din, a_gnt       transmit-write requester
//     b_req, b_gnt              receive-read requester
//     b_dout, b_valid           registered read data and its one-cycle strobe
//     wr, rd, addr, din, dout   UART register bus
//     cfg_done, busy            configured flag, sequence-in-progress flag
module uart_bus_ctrl
  import uart_bus_ctrl_pkg::*;
#(
  parameter int unsigned CFG_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] divisor,
  input  logic [7:0]  lcr_cfg,
  input  logic [7:0]  fcr_cfg,
  input  logic        a_req,
  input  logic [7:0]  a_din,
  output logic        a_gnt,
  input  logic        b_req,
  output logic        b_gnt,
  output logic [7:0]  b_dout,
  output logic        b_valid,
  output logic        wr,
  output logic        rd,
  output logic [2:0]  addr,
  output logic [7:0]  din,
  input  logic [7:0]  dout,
  output logic        cfg_done,
  output logic        busy
);

  // Load value for the gap counter. The gap state is entered only when
  // CFG_GAP is non-zero, so the wrap at CFG_GAP=0 is never used.
  localparam logic [2:0] GAP_LAST = 3'(CFG_GAP - 1);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;          // write state to resume after the gap
  logic [2:0]  gap_cnt_q, gap_cnt_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] div_q;
  logic [6:0]  lcr_q;                 // bit7 of lcr_cfg is replaced by DLAB
  logic [7:0]  fcr_q;
  logic [7:0]  b_dout_q;
  logic        b_valid_q;
  logic        start_ok;
  logic        arb_en;

  assign start_ok = start & ((state_q == IDLE) | (state_q == RUN));

  // A start in RUN takes the bus for reconfiguration, so no grant that cycle.
  assign arb_en = (state_q == RUN) & ~start;

  uart_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en_i    (arb_en),
    .req_a_i (a_req),
    .req_b_i (b_req),
    .gnt_a_o (a_gnt),
    .gnt_b_o (b_gnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      gap_cnt_q  <= 3'd0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      gap_cnt_q  <= gap_cnt_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    gap_cnt_d  = gap_cnt_q;
    cfg_done_d = cfg_done_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_ok) begin
          state_d    = W_LCRD;
          cfg_done_d = 1'b0;
        end
      end
      W_LCRD, W_DLL, W_DLM, W_LCR, W_FCR: begin
        if (CFG_GAP == 0) begin
          state_d = next_write(state_q);
        end else begin
          state_d   = GAP;
          ret_d     = next_write(state_q);
          gap_cnt_d = GAP_LAST;
        end
      end
      GAP: begin
        if (gap_cnt_q == 3'd0) begin
          state_d = ret_q;
        end else begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // cfg_done rises in the first RUN cycle after the sequence.
    if ((state_d == RUN) && (state_q != RUN)) begin
      cfg_done_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    wr   = 1'b0;
    rd   = 1'b0;
    addr = ADDR_THR;
    din  = 8'h00;
    case (state_q)
      W_LCRD: begin
        wr            = 1'b1;
        addr          = ADDR_LCR;
        din           = {1'b0, lcr_q};
        din[DLAB_BIT] = 1'b1;
      end
      W_DLL: begin
        wr   = 1'b1;
        addr = ADDR_DLL;
        din  = div_q[7:0];
      end
      W_DLM: begin
        wr   = 1'b1;
        addr = ADDR_DLM;
        din  = div_q[15:8];
      end
      W_LCR: begin
        wr   = 1'b1;
        addr = ADDR_LCR;
        din  = {1'b0, lcr_q};
      end
      W_FCR: begin
        wr   = 1'b1;
        addr = ADDR_FCR;
        din  = fcr_q;
      end
      RUN: begin
        if (a_gnt) begin
          wr  = 1'b1;
          din = a_din;
        end else if (b_gnt) begin
          rd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Configuration latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= 16'h0000;
      lcr_q     <= 7'h00;
      fcr_q     <= 8'h00;
      b_dout_q  <= 8'h00;
      b_valid_q <= 1'b0;
    end else begin
      if (start_ok) begin
        div_q <= divisor;
        lcr_q <= lcr_cfg[6:0];
        fcr_q <= fcr_cfg;
      end
      b_valid_q <= b_gnt;
      if (b_gnt) begin
        b_dout_q <= dout;
      end
    end
  end

  assign b_dout   = b_dout_q;
  assign b_valid  = b_valid_q;
  assign cfg_done = cfg_done_q;
  assign busy     = (state_q != IDLE) && (state_q != RUN);

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] divisor = 16'h0000;
  logic [7:0]  lcr_cfg = 8'h00;
  logic [7:0]  fcr_cfg = 8'h00;
  logic        a_req = 1'b0;
  logic [7:0]  a_din = 8'h00;
  logic        a_gnt;
  logic        b_req = 1'b0;
  logic        b_gnt;
  logic [7:0]  b_dout;
  logic        b_valid;
  logic        wr, rd;
  logic [2:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout = 8'h00;
  logic        cfg_done, busy;

  int errors = 0;
  int checks = 0;

  uart_bus_ctrl #(.CFG_GAP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .divisor(divisor),
    .lcr_cfg(lcr_cfg), .fcr_cfg(fcr_cfg),
    .a_req(a_req), .a_din(a_din), .a_gnt(a_gnt),
    .b_req(b_req), .b_gnt(b_gnt), .b_dout(b_dout), .b_valid(b_valid),
    .wr(wr), .rd(rd), .addr(addr), .din(din), .dout(dout),
    .cfg_done(cfg_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr, rd, a_gnt, b_gnt, b_valid, cfg_done, busy, addr, din, b_dout} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b rd=%0b ag=%0b bg=%0b bv=%0b done=%0b busy=%0b addr=%0d din=%02h bdout=%02h want all 0",
               wr, rd, a_gnt, b_gnt, b_valid, cfg_done, busy, addr, din, b_dout);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, wr, rd, busy} !== 5'd0) begin
      errors++;
      $display("FAIL idle_no_grant: got ag=%0b bg=%0b wr=%0b rd=%0b busy=%0b want 0", a_gnt, b_gnt, wr, rd, busy);
    end
    a_req = 1'b0; b_req = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_config();
    logic [2:0] ea [5];
    logic [7:0] ed [5];
    logic       ew;
    logic [2:0] eaddr;
    logic [7:0] edin;
    ea[0] = 3'd3; ed[0] = 8'h9B;
    ea[1] = 3'd0; ed[1] = 8'h45;
    ea[2] = 3'd1; ed[2] = 8'h01;
    ea[3] = 3'd3; ed[3] = 8'h1B;
    ea[4] = 3'd2; ed[4] = 8'h07;
    divisor = 16'h0145; lcr_cfg = 8'h1B; fcr_cfg = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      ew    = (k < 10) && (k % 2 == 0);
      eaddr = ew ? ea[k/2] : 3'd0;
      edin  = ew ? ed[k/2] : 8'h00;
      checks++;
      if ({wr, rd, addr, din} !== {ew, 1'b0, eaddr, edin}) begin
        errors++;
        $display("FAIL cfg_bus[%0d]: got wr=%0b rd=%0b addr=%0d din=%02h want wr=%0b rd=0 addr=%0d din=%02h",
                 k, wr, rd, addr, din, ew, eaddr, edin);
      end
      checks++;
      if ({cfg_done, busy} !== {(k == 10), (k < 10)}) begin
        errors++;
        $display("FAIL cfg_flags[%0d]: got done=%0b busy=%0b want done=%0b busy=%0b",
                 k, cfg_done, busy, (k == 10), (k < 10));
      end
      if (k < 10) @(negedge clk);
    end
    $display("test_config done");
  endtask

  task automatic test_fairness();
    logic ea, eb, ev;
    a_req = 1'b1; b_req = 1'b1; a_din = 8'h11;
    for (int i = 0; i < 6; i++) begin
      dout = 8'(8'h5A + i);
      #1;
      ea = (i % 2 == 0);
      eb = ~ea;
      ev = (i > 0) && ea;
      checks++;
      if ({a_gnt, b_gnt, wr, rd, addr, din} !== {ea, eb, ea, eb, 3'd0, (ea ? 8'h11 : 8'h00)}) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got ag=%0b bg=%0b wr=%0b rd=%0b addr=%0d din=%02h want ag=%0b bg=%0b",
                 i, a_gnt, b_gnt, wr, rd, addr, din, ea, eb);
      end
      checks++;
      if (b_valid !== ev) begin
        errors++;
        $display("FAIL fair_bvalid[%0d]: got %0b want %0b", i, b_valid, ev);
      end
      if (ev) begin
        checks++;
        if (b_dout !== 8'(8'h5A + i - 1)) begin
          errors++;
          $display("FAIL fair_bdout[%0d]: got %02h want %02h", i, b_dout, 8'(8'h5A + i - 1));
        end
      end
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    checks++;
    if ({b_valid, b_dout, a_gnt, b_gnt} !== {1'b1, 8'h5F, 2'b00}) begin
      errors++;
      $display("FAIL fair_last_read: got bv=%0b bdout=%02h ag=%0b bg=%0b want bv=1 bdout=5f no grant",
               b_valid, b_dout, a_gnt, b_gnt);
    end
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b0) begin
      errors++;
      $display("FAIL fair_bvalid_pulse: got %0b want 0", b_valid);
    end
    $display("test_fairness done");
  endtask

  task automatic test_holdoff();
    int n = 0;
    a_din = 8'hC3; a_req = 1'b1;
    divisor = 16'h0145; lcr_cfg = 8'h1B; fcr_cfg = 8'h07; start = 1'b1;
    #1;
    checks++;
    if ({a_gnt, wr} !== 2'b00) begin
      errors++;
      $display("FAIL hold_start_prio: got ag=%0b wr=%0b want 0 0", a_gnt, wr);
    end
    @(negedge clk);
    start = 1'b0;
    while (cfg_done !== 1'b1 && n < 30) begin
      checks++;
      if (a_gnt !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_grant[%0d]: got ag=%0b want 0", n, a_gnt);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (cfg_done !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL hold_done_time: got done=%0b after %0d cycles want done=1 after 10", cfg_done, n);
    end
    checks++;
    if ({a_gnt, wr, rd, addr, din} !== {3'b110, 3'd0, 8'hC3}) begin
      errors++;
      $display("FAIL hold_first_grant: got ag=%0b wr=%0b rd=%0b addr=%0d din=%02h want ag=1 wr=1 rd=0 addr=0 din=c3",
               a_gnt, wr, rd, addr, din);
    end
    @(posedge clk);
    #1 a_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_gnt, wr} !== 2'b00) begin
      errors++;
      $display("FAIL hold_released: got ag=%0b wr=%0b want 0 0", a_gnt, wr);
    end
    $display("test_holdoff done");
  endtask

  task automatic test_priority();
    logic [2:0] ea [5];
    logic [7:0] ed [5];
    logic       ew;
    logic [2:0] eaddr;
    logic [7:0] edin;
    ea[0] = 3'd3; ed[0] = 8'h83;
    ea[1] = 3'd0; ed[1] = 8'h34;
    ea[2] = 3'd1; ed[2] = 8'h12;
    ea[3] = 3'd3; ed[3] = 8'h03;
    ea[4] = 3'd2; ed[4] = 8'hC1;
    a_req = 1'b1; b_req = 1'b1; a_din = 8'h77; dout = 8'hE7;
    divisor = 16'h1234; lcr_cfg = 8'h83; fcr_cfg = 8'hC1; start = 1'b1;
    #1;
    checks++;
    if ({a_gnt, b_gnt, wr, rd, busy} !== 5'd0) begin
      errors++;
      $display("FAIL prio_no_grant: got ag=%0b bg=%0b wr=%0b rd=%0b busy=%0b want 0", a_gnt, b_gnt, wr, rd, busy);
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) start = 1'b0;
      ew    = (k % 2 == 0);
      eaddr = ew ? ea[k/2] : 3'd0;
      edin  = ew ? ed[k/2] : 8'h00;
      checks++;
      if ({a_gnt, b_gnt, wr, rd, addr, din, busy} !== {2'b00, ew, 1'b0, eaddr, edin, 1'b1}) begin
        errors++;
        $display("FAIL prio_seq[%0d]: got ag=%0b bg=%0b wr=%0b rd=%0b addr=%0d din=%02h busy=%0b want wr=%0b addr=%0d din=%02h busy=1",
                 k, a_gnt, b_gnt, wr, rd, addr, din, busy, ew, eaddr, edin);
      end
      if (k == 1) begin
        // start while busy: different values that must not be picked up
        divisor = 16'hFFFF; lcr_cfg = 8'h7F; fcr_cfg = 8'hFF; start = 1'b1;
      end
      @(negedge clk);
    end
    // Last winner is A (from the hold-off test), so B is granted first.
    checks++;
    if ({cfg_done, a_gnt, b_gnt, wr, rd} !== 5'b10101) begin
      errors++;
      $display("FAIL prio_first_run: got done=%0b ag=%0b bg=%0b wr=%0b rd=%0b want done=1 bg=1 rd=1",
               cfg_done, a_gnt, b_gnt, wr, rd);
    end
    @(posedge clk);
    #1 b_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_gnt, wr, din, b_valid, b_dout} !== {2'b11, 8'h77, 1'b1, 8'hE7}) begin
      errors++;
      $display("FAIL prio_next: got ag=%0b wr=%0b din=%02h bv=%0b bdout=%02h want ag=1 wr=1 din=77 bv=1 bdout=e7",
               a_gnt, wr, din, b_valid, b_dout);
    end
    @(posedge clk);
    #1 a_req = 1'b0;
    @(negedge clk);
    $display("test_priority done");
  endtask

  task automatic test_abort();
    divisor = 16'h0145; lcr_cfg = 8'h1B; fcr_cfg = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({wr, addr, din} !== {1'b1, 3'd1, 8'h01}) begin
      errors++;
      $display("FAIL abort_at_dlm: got wr=%0b addr=%0d din=%02h want wr=1 addr=1 din=01", wr, addr, din);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wr, rd, a_gnt, b_gnt, b_valid, cfg_done, busy, addr, din, b_dout} !== 26'd0) begin
      errors++;
      $display("FAIL abort_outputs: got wr=%0b rd=%0b done=%0b busy=%0b addr=%0d din=%02h bv=%0b want all 0",
               wr, rd, cfg_done, busy, addr, din, b_valid);
    end
    a_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({wr, rd, a_gnt, busy, cfg_done} !== 5'd0) begin
        errors++;
        $display("FAIL abort_quiet[%0d]: got wr=%0b rd=%0b ag=%0b busy=%0b done=%0b want 0",
                 i, wr, rd, a_gnt, busy, cfg_done);
      end
    end
    a_req = 1'b0;
    $display("test_abort done");
  endtask

  initial begin
    test_reset();
    test_config();
    test_fairness();
    test_holdoff();
    test_priority();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 Parameter: CFG_GAP, default 1, number of idle bus cycles inserted after each configuration write (0..7).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that requests the configuration sequence.
REQ-005 divisor  input  16  baud divisor, sampled on the accepted start.
REQ-006 lcr_cfg  input  8  line-control value, sampled on the accepted start; bit7 is ignored.
REQ-007 fcr_cfg  input  8  FIFO-control value, sampled on the accepted start.
REQ-008 a_req / a_din / a_gnt  input 1 / input 8 / output 1  transmit-write requester.
REQ-009 b_req / b_gnt  input 1 / output 1  receive-read requester.
REQ-010 b_dout / b_valid  output 8 / output 1  read data and its valid strobe.
REQ-011 wr, rd, addr, din  output 1, 1, 3, 8  register bus to the UART.
REQ-012 dout  input  8  UART read data, combinationally valid in the cycle rd=1.
REQ-013 cfg_done / busy  output 1 / output 1  configured flag / sequence-in-progress flag.

Function
REQ-014 The FSM SHALL have these states: IDLE, W_LCRD, W_DLL, W_DLM, W_LCR, W_FCR, GAP, RUN.
REQ-015 In IDLE or RUN, start SHALL be accepted; the block then latches divisor, lcr_cfg and fcr_cfg, clears cfg_done and enters W_LCRD on the next cycle.
REQ-016 The configuration writes SHALL occur in this order, each as one cycle with wr=1:
  - addr 3, din {1,lcr_cfg[6:0]}
  - addr 0, din divisor[7:0]
  - addr 1, din divisor[15:8]
  - addr 3, din {0,lcr_cfg[6:0]}
  - addr 2, din fcr_cfg
REQ-017 After each configuration write, the FSM SHALL spend CFG_GAP cycles in GAP with wr=rd=0; the GAP state is skipped when CFG_GAP=0.
REQ-018 After the W_FCR write and its gap, the FSM SHALL enter RUN and set cfg_done=1 in the same cycle.
REQ-019 busy SHALL be 1 in every state other than IDLE and RUN.
REQ-020 In RUN, at most one requester SHALL be granted per cycle, and a grant SHALL be combinational with the bus access in that same cycle.
REQ-021 An a_gnt cycle SHALL drive wr=1, addr=0, din=a_din.
REQ-022 A b_gnt cycle SHALL drive rd=1, addr=0; dout is registered into b_dout and b_valid=1 for exactly the next cycle.
REQ-023 Arbitration SHALL be round-robin on a 1-bit last-winner flag (reset value: B, so A wins first); a lone requester SHALL win every cycle.
REQ-024 With both requesters active continuously, grants SHALL alternate A, B, A, B ...
REQ-025 A start coincident with requests SHALL take priority: no grant is issued in that cycle.
REQ-026 Requests in IDLE or during the sequence SHALL receive no grant; they are held off, not dropped, because requesters keep req asserted until granted.
REQ-027 A start while busy=1 SHALL be ignored.
REQ-028 When not granted or sequencing, the bus outputs SHALL be wr=0, rd=0, addr=0, din=0.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL hold on the next cycle:
  - state IDLE
  - wr, rd, a_gnt, b_gnt, b_valid, cfg_done, busy all 0
  - addr=0, din=0, b_dout=0
  - latched configuration values 0, last-winner flag = B
REQ-030 rst SHALL abort a sequence in progress with no further bus writes; a new start is then required.

Structure
REQ-031 A shared package SHALL hold the state enum and the register address constants (THR/DLL=0, DLM=1, FCR=2, LCR=3) plus the DLAB bit index 7.
REQ-032 One sub-module, uart_rr_arb2 (2-way round-robin arbiter), SHALL hold the grant logic and the last-winner flag.

Verification
REQ-033 Config test: CFG_GAP=1, start with divisor=0x0145, lcr_cfg=0x1B, fcr_cfg=0x07 -> writes (3,0x9B), (0,0x45), (1,0x01), (3,0x1B), (2,0x07), each followed by one idle cycle; cfg_done rises 10 cycles after the accepted start.
REQ-034 Hold-off test: a_req=1 from the start pulse onward -> a_gnt stays 0 until cfg_done=1; the first a_gnt then drives wr=1, addr=0, din=a_din.
REQ-035 Fairness test: a_req=b_req=1 for 6 RUN cycles -> grant order A, B, A, B, A, B; each b_gnt is followed one cycle later by b_valid=1 with b_dout equal to the dout value driven (e.g. 0x5A).
REQ-036 Priority test: start coincident with a_req in RUN -> no grant that cycle, and the next bus activity is a write to addr 3 with bit7=1; a start pulsed while busy=1 produces no change.
REQ-037 Abort test: rst asserted during W_DLM -> next cycle the FSM is in IDLE with all outputs 0 and no later bus writes until a new start.
